// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM states and constants for the serial pattern detector.
package seq_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam int         PAT_W    = 4;
    localparam logic [1:0] FILL_MAX = 2'd3;
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: overlapping 4-bit matcher with history and fill tracking.
module seq_match_core
    import seq_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_bit,
    input  logic             i_bit_en,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic             i_clr,
    output logic             o_hit,
    output logic             o_match
);
    logic [PAT_W-2:0] r_hist;
    logic [1:0]       r_fill;
    logic             r_match;

    // Combinational hit lets the parent update its counter on the same edge as the pulse.
    assign o_hit   = i_bit_en & (r_fill == FILL_MAX) & ({r_hist, i_bit} == i_pattern);
    assign o_match = r_match;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else begin
            r_match <= o_hit & ~i_clr;
            if (i_clr) begin
                r_hist <= '0;
                r_fill <= '0;
            end else if (i_bit_en) begin
                r_hist <= {r_hist[PAT_W-3:0], i_bit};
                r_fill <= (r_fill == FILL_MAX) ? FILL_MAX : r_fill + 2'd1;
            end
        end
    end
endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts words over valid/ready, serializes MSB first into the
// matcher, counts matches with saturation and raises a sticky threshold irq.
module seq_scan_ctrl
    import seq_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [WORD_W-1:0] i_in_data,
    input  logic [PAT_W-1:0]  i_cfg_pattern,
    input  logic [CNT_W-1:0]  i_cfg_thresh,
    input  logic              i_clr,
    output logic              o_busy,
    output logic              o_match_pulse,
    output logic [CNT_W-1:0]  o_match_count,
    output logic              o_irq
);
    localparam int              BC_W = $clog2(WORD_W);
    localparam logic [BC_W-1:0] LAST = BC_W'(WORD_W - 1);

    state_t            r_state, w_state_nxt;
    logic [WORD_W-1:0] r_shift;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]  r_count, w_count_inc;
    logic              r_irq;
    logic              w_last, w_load, w_hit;

    assign w_last      = (r_state == SHIFT) & (r_bit_cnt == LAST);
    assign o_in_ready  = (r_state == IDLE) | w_last;
    assign o_busy      = (r_state == SHIFT);
    assign w_load      = i_in_valid & o_in_ready;
    assign w_count_inc = (r_count == '1) ? r_count : r_count + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // A load on the last bit keeps SHIFT, giving back-to-back words with no bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = w_load ? SHIFT : (w_last ? IDLE : r_state);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_load) begin
            r_shift   <= i_in_data;
            r_bit_cnt <= '0;
        end else if (o_busy) begin
            r_shift   <= {r_shift[WORD_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    seq_match_core u_core (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_bit     (r_shift[WORD_W-1]),
        .i_bit_en  (o_busy),
        .i_pattern (i_cfg_pattern),
        .i_clr     (i_clr),
        .o_hit     (w_hit),
        .o_match   (o_match_pulse)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_irq   <= 1'b0;
        end else if (i_clr) begin
            r_count <= '0;
            r_irq   <= 1'b0;
        end else if (w_hit) begin
            r_count <= w_count_inc;
            if ((i_cfg_thresh != '0) && (w_count_inc == i_cfg_thresh)) r_irq <= 1'b1;
        end
    end

    assign o_match_count = r_count;
    assign o_irq         = r_irq;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: scoreboard bench; a bit-queue reference model predicts every
// cycle's outputs and a negedge monitor pops and compares them.
module tb_seq_scan_ctrl;
    localparam int WORD_W = 8;
    localparam int CNT_W  = 3;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0, rst_n = 1'b0, valid = 1'b0, clr = 1'b0;
    logic [WORD_W-1:0] data = '0;
    logic [3:0]        pattern = '0;
    logic [CNT_W-1:0]  thresh = '0;
    logic              ready, busy, pulse, irq;
    logic [CNT_W-1:0]  count;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_in_valid    (valid),
        .o_in_ready    (ready),
        .i_in_data     (data),
        .i_cfg_pattern (pattern),
        .i_cfg_thresh  (thresh),
        .i_clr         (clr),
        .o_busy        (busy),
        .o_match_pulse (pulse),
        .o_match_count (count),
        .o_irq         (irq)
    );

    typedef struct packed {
        logic             pulse;
        logic [CNT_W-1:0] count;
        logic             irq;
        logic             busy;
        logic             ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0, n_pass = 0;
    bit   pend[$];
    bit   hist[$];
    int   m_count = 0;
    bit   m_irq = 1'b0;
    bit   accepted = 1'b0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    // Pending bits are consumed one per edge; the last 4 consumed bits since clr form the window.
    task automatic model_step();
        bit   b, ready_now, hit;
        exp_t e;
        ready_now = pend.size() <= 1;
        hit = 1'b0;
        if (pend.size() > 0) begin
            b = pend.pop_front();
            hist.push_back(b);
            if (hist.size() > 4) void'(hist.pop_front());
            hit = (hist.size() == 4) && ({hist[0], hist[1], hist[2], hist[3]} == pattern);
        end
        if (clr) begin
            hist.delete();
            m_count = 0;
            m_irq = 1'b0;
            hit = 1'b0;
        end else if (hit) begin
            if (m_count < CMAX) m_count++;
            if (thresh != 0 && m_count == thresh) m_irq = 1'b1;
        end
        accepted = valid && ready_now;
        if (accepted) for (int i = WORD_W - 1; i >= 0; i--) pend.push_back(data[i]);
        e.pulse = hit;
        e.count = CNT_W'(m_count);
        e.irq   = m_irq;
        e.busy  = pend.size() > 0;
        e.ready = pend.size() <= 1;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(input logic [WORD_W-1:0] w);
        int n;
        n = 0;
        valid = 1'b1;
        data = w;
        do begin
            tick();
            n++;
        end while (!accepted && n < 40);
        if (!accepted) check("accept_timeout", 0, 1);
        valid = 1'b0;
        data = WORD_W'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (pend.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("match_pulse", pulse, e.pulse);
                check("match_count", count, e.count);
                check("irq", irq, e.irq);
                check("busy", busy, e.busy);
                check("in_ready", ready, e.ready);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_pulse", pulse, 0);
        check("rst_count", count, 0);
        check("rst_irq", irq, 0);
        rst_n = 1'b1;

        pattern = 4'b1011;
        pulse_clr();
        send(8'hB6);
        drain();
        check("b6_count", count, 2);

        pulse_clr();
        send(8'h05);
        send(8'h80);
        drain();
        check("cross_word_count", count, 1);

        pattern = 4'b0000;
        pulse_clr();
        send(8'h00);
        drain();
        check("zeros_count", count, 5);
        send(8'h00);
        drain();
        check("zeros_saturate", count, 7);

        pattern = 4'b1011;
        thresh = 3'd3;
        pulse_clr();
        send(8'hB6);
        send(8'hB6);
        drain();
        check("thresh_count", count, 4);
        check("thresh_irq", irq, 1);
        pulse_clr();
        check("clr_count", count, 0);
        check("clr_irq", irq, 0);

        thresh = '0;
        send(8'hB6);
        repeat (3) tick();
        pulse_clr();
        drain();
        check("clr_on_match_count", count, 0);
        check("clr_on_match_irq", irq, 0);

        send(8'hB6);
        repeat (4) tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", ready, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_pulse", pulse, 0);
        check("async_rst_count", count, 0);
        check("async_rst_irq", irq, 0);
        pend.delete();
        hist.delete();
        m_count = 0;
        m_irq = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_ready", ready, 1);
        send(8'hB0);
        drain();
        check("post_rst_count", count, 1);

        for (int k = 0; k < 400; k++) begin
            valid = ($urandom_range(0, 9) < 7);
            data  = WORD_W'($urandom);
            clr   = ($urandom_range(0, 29) == 0);
            if (pend.size() == 0 && $urandom_range(0, 9) == 0) begin
                pattern = 4'($urandom);
                thresh  = CNT_W'($urandom);
            end
            tick();
        end
        valid = 1'b0;
        clr = 1'b0;
        drain();
        @(negedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
